// File: rtl/sample_fetch_arbiter.sv
// Round-robin share of the multi-thread random-word buffer among NUM_REQ sampling consumers.
// Latency: req->gnt 1 cycle, gnt->valid 1 cycle when a thread is ready; 3 cycles minimum per word.
// Backpressure: word held until ack on the granted bit; FETCH waits for a ready thread (SAMPLE_FETCH_ARB_TIMEOUT_EN bounds the wait).
module sample_fetch_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int NUM_THREADS = 4,
    parameter int TIMEOUT     = 255,
    localparam int RW = $clog2(NUM_REQ),
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                      clk_sample,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        ack,
    input  logic [NUM_THREADS-1:0]    buf_ready,
    input  logic [32*NUM_THREADS-1:0] buf_data,
    output logic [NUM_THREADS-1:0]    buf_rd,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      valid,
    output logic [31:0]               data_out,
    output logic [TW-1:0]             thread_id,
    output logic                      starve
);

    typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_t;

    state_t                 state, state_nxt;
    logic [RW-1:0]          rr_req, rr_req_nxt;
    logic [TW-1:0]          rr_thr, rr_thr_nxt;
    logic [RW-1:0]          gidx, gidx_nxt;
    logic [NUM_REQ-1:0]     gnt_nxt;
    logic                   valid_nxt;
    logic [31:0]            data_nxt;
    logic [TW-1:0]          tid_nxt;
    logic [NUM_THREADS-1:0] buf_rd_nxt;
    logic                   starve_nxt;

    logic                   req_hit, thr_hit;
    logic [RW-1:0]          req_pick;
    logic [TW-1:0]          thr_pick;

    // Scan downward so the lowest offset from the pointer is the final winner.
    function automatic logic [RW:0] pick_req(input logic [NUM_REQ-1:0] v, input logic [RW-1:0] start);
        logic [RW:0] res;
        int j;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = (int'(start) + i) % NUM_REQ;
            if (v[j]) res = {1'b1, RW'(j)};
        end
        return res;
    endfunction

    function automatic logic [TW:0] pick_thr(input logic [NUM_THREADS-1:0] v, input logic [TW-1:0] start);
        logic [TW:0] res;
        int j;
        res = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            j = (int'(start) + i) % NUM_THREADS;
            if (v[j]) res = {1'b1, TW'(j)};
        end
        return res;
    endfunction

    // A thread being read this cycle still shows a stale ready, so it is masked.
    always_comb begin
        {req_hit, req_pick} = pick_req(req, rr_req);
        {thr_hit, thr_pick} = pick_thr(buf_ready & ~buf_rd, rr_thr);
    end

`ifdef SAMPLE_FETCH_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt, cnt_nxt;
`endif

    always_comb begin
        state_nxt  = state;
        rr_req_nxt = rr_req;
        rr_thr_nxt = rr_thr;
        gidx_nxt   = gidx;
        gnt_nxt    = gnt;
        valid_nxt  = valid;
        data_nxt   = data_out;
        tid_nxt    = thread_id;
        buf_rd_nxt = '0;
        starve_nxt = 1'b0;
`ifdef SAMPLE_FETCH_ARB_TIMEOUT_EN
        cnt_nxt    = cnt;
`endif
        case (state)
            IDLE: begin
                if (req_hit) begin
                    gnt_nxt           = '0;
                    gnt_nxt[req_pick] = 1'b1;
                    gidx_nxt          = req_pick;
                    state_nxt         = FETCH;
`ifdef SAMPLE_FETCH_ARB_TIMEOUT_EN
                    cnt_nxt           = '0;
`endif
                end
            end
            FETCH: begin
                if (thr_hit) begin
                    data_nxt             = buf_data[32*thr_pick +: 32];
                    tid_nxt              = thr_pick;
                    buf_rd_nxt[thr_pick] = 1'b1;
                    rr_thr_nxt           = (thr_pick == TW'(NUM_THREADS - 1)) ? '0 : thr_pick + 1'b1;
                    valid_nxt            = 1'b1;
                    state_nxt            = DELIVER;
                end
`ifdef SAMPLE_FETCH_ARB_TIMEOUT_EN
                else if (32'(cnt) + 1 >= TIMEOUT) begin
                    starve_nxt = 1'b1;
                    gnt_nxt    = '0;
                    rr_req_nxt = (gidx == RW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
`endif
            end
            DELIVER: begin
                if (ack[gidx]) begin
                    valid_nxt  = 1'b0;
                    gnt_nxt    = '0;
                    rr_req_nxt = (gidx == RW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sample or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            rr_req    <= '0;
            rr_thr    <= '0;
            gidx      <= '0;
            gnt       <= '0;
            valid     <= 1'b0;
            data_out  <= '0;
            thread_id <= '0;
            buf_rd    <= '0;
        end else begin
            state     <= state_nxt;
            rr_req    <= rr_req_nxt;
            rr_thr    <= rr_thr_nxt;
            gidx      <= gidx_nxt;
            gnt       <= gnt_nxt;
            valid     <= valid_nxt;
            data_out  <= data_nxt;
            thread_id <= tid_nxt;
            buf_rd    <= buf_rd_nxt;
        end
    end

`ifdef SAMPLE_FETCH_ARB_TIMEOUT_EN
    always_ff @(posedge clk_sample or negedge rstn) begin
        if (!rstn) begin
            cnt    <= '0;
            starve <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            starve <= starve_nxt;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0) | starve_nxt;
    assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_sample_fetch_arbiter.sv
// Directed bench for sample_fetch_arbiter; immediate assertions at every comparison point.
module tb_sample_fetch_arbiter;

    localparam int NR = 4;
    localparam int NT = 4;
`ifdef SAMPLE_FETCH_ARB_TIMEOUT_EN
    localparam int WAIT_CYC = 3;
`else
    localparam int WAIT_CYC = 10;
`endif

    logic              clk_sample;
    logic              rstn;
    logic [NR-1:0]     req, ack;
    logic [NT-1:0]     buf_ready;
    logic [32*NT-1:0]  buf_data;
    logic [NT-1:0]     buf_rd;
    logic [NR-1:0]     gnt;
    logic              valid;
    logic [31:0]       data_out;
    logic [1:0]        thread_id;
    logic              starve;

    int checks = 0;
    int failures = 0;
    logic [NT-1:0] prev_rd = '0;

    sample_fetch_arbiter #(.NUM_REQ(NR), .NUM_THREADS(NT), .TIMEOUT(4)) dut (
        .clk_sample(clk_sample), .rstn(rstn), .req(req), .ack(ack),
        .buf_ready(buf_ready), .buf_data(buf_data), .buf_rd(buf_rd),
        .gnt(gnt), .valid(valid), .data_out(data_out),
        .thread_id(thread_id), .starve(starve)
    );

    initial begin
        clk_sample = 1'b0;
        forever #5 clk_sample = ~clk_sample;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sample);
        #1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_gnt"}, 64'(gnt), 64'h0);
        chk({tag, "_valid"}, 64'(valid), 64'h0);
        chk({tag, "_rd"}, 64'(buf_rd), 64'h0);
        chk({tag, "_data"}, 64'(data_out), 64'h0);
        chk({tag, "_tid"}, 64'(thread_id), 64'h0);
        chk({tag, "_starve"}, 64'(starve), 64'h0);
    endtask

    // Read-pulse invariants: one-hot and never the same thread on back-to-back cycles.
    always @(negedge clk_sample) begin
        if (rstn && buf_rd != '0) begin
            chk("rd_onehot", 64'($countones(buf_rd)), 64'd1);
            chk("rd_consec", 64'(buf_rd & prev_rd), 64'h0);
        end
        prev_rd = buf_rd;
    end

    initial begin
        logic [NR-1:0] exp_g;
        logic [NT-1:0] exp_r;
        rstn = 1'b0; req = '0; ack = '0; buf_ready = '0; buf_data = '0;
        tick(); tick();
        chk_idle_outs("reset");
        rstn = 1'b1;

        // 1: single word
        req = 4'b0001; buf_ready = 4'b0001; buf_data[31:0] = 32'hA5A5_0001;
        tick();
        chk("t1_gnt", 64'(gnt), 64'h1);
        chk("t1_valid0", 64'(valid), 64'h0);
        tick();
        chk("t1_rd", 64'(buf_rd), 64'h1);
        chk("t1_valid", 64'(valid), 64'h1);
        chk("t1_data", 64'(data_out), 64'hA5A5_0001);
        chk("t1_tid", 64'(thread_id), 64'h0);
        req = '0; ack = 4'b0001;
        tick();
        chk("t1_gnt_clr", 64'(gnt), 64'h0);
        chk("t1_valid_clr", 64'(valid), 64'h0);
        chk("t1_rd_clr", 64'(buf_rd), 64'h0);
        ack = '0;

        // 2: full contention after a fresh reset
        rstn = 1'b0; #1; rstn = 1'b1;
        for (int t = 0; t < NT; t++) buf_data[32*t +: 32] = 32'hD0D0_0000 + 32'(t);
        req = 4'b1111; buf_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = NR'(1) << (k % NR);
            exp_r = NT'(1) << (k % NT);
            tick();
            chk("t2_gnt", 64'(gnt), 64'(exp_g));
            tick();
            chk("t2_rd", 64'(buf_rd), 64'(exp_r));
            chk("t2_data", 64'(data_out), 64'(32'hD0D0_0000 + 32'(k % NT)));
            chk("t2_tid", 64'(thread_id), 64'(k % NT));
            ack = exp_g;
            tick();
            chk("t2_valid_clr", 64'(valid), 64'h0);
            ack = '0;
        end
        req = '0;

        // 3: wait in FETCH for a ready thread (rr_req=1, rr_thr=1)
        req = 4'b0010; buf_ready = '0;
        tick();
        chk("t3_gnt", 64'(gnt), 64'h2);
        for (int i = 0; i < WAIT_CYC; i++) begin
            tick();
            chk("t3_gnt_hold", 64'(gnt), 64'h2);
            chk("t3_no_rd", 64'(buf_rd), 64'h0);
        end
        buf_ready = 4'b0100; buf_data[64 +: 32] = 32'h0280_F76B;
        tick();
        chk("t3_rd", 64'(buf_rd), 64'h4);
        chk("t3_data", 64'(data_out), 64'h0280_F76B);
        chk("t3_tid", 64'(thread_id), 64'h2);
        chk("t3_valid", 64'(valid), 64'h1);
        buf_ready = '0; req = '0;

        // 4: wrong-bit acks ignored
        ack = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_valid_hold", 64'(valid), 64'h1);
            chk("t4_gnt_hold", 64'(gnt), 64'h2);
            chk("t4_data_hold", 64'(data_out), 64'h0280_F76B);
        end
        ack = 4'b0010;
        tick();
        chk("t4_valid_clr", 64'(valid), 64'h0);
        chk("t4_gnt_clr", 64'(gnt), 64'h0);
        ack = '0;

        // 5: reset during FETCH (rr_req=2 picks requester 0)
        req = 4'b0001;
        tick();
        chk("t5_gnt", 64'(gnt), 64'h1);
        buf_ready = 4'b1111; rstn = 1'b0;
        #1;
        chk_idle_outs("t5_async");
        tick();
        chk("t5_no_rd", 64'(buf_rd), 64'h0);
        chk("t5_gnt_rst", 64'(gnt), 64'h0);
        rstn = 1'b1; req = 4'b1111;
        tick();
        chk("t5_gnt_restart", 64'(gnt), 64'h1);
        tick();
        chk("t5_rd_restart", 64'(buf_rd), 64'h1);
        chk("t5_tid_restart", 64'(thread_id), 64'h0);
        req = '0; ack = 4'b0001; buf_ready = '0;
        tick();
        chk("t5_valid_clr", 64'(valid), 64'h0);
        ack = '0;

        // 6: starvation (rr_req=1, only requester 0 asks)
        req = 4'b0001;
        tick();
        chk("t6_gnt", 64'(gnt), 64'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_starve_lo", 64'(starve), 64'h0);
            chk("t6_gnt_hold", 64'(gnt), 64'h1);
        end
        tick();
`ifdef SAMPLE_FETCH_ARB_TIMEOUT_EN
        chk("t6_starve", 64'(starve), 64'h1);
        chk("t6_gnt_clr", 64'(gnt), 64'h0);
        chk("t6_no_rd", 64'(buf_rd), 64'h0);
        req = '0;
        tick();
        chk("t6_starve_pulse", 64'(starve), 64'h0);
        chk("t6_idle_gnt", 64'(gnt), 64'h0);
`else
        chk("t6_starve_off", 64'(starve), 64'h0);
        chk("t6_gnt_wait", 64'(gnt), 64'h1);
        req = '0;
        tick();
        chk("t6_starve_off2", 64'(starve), 64'h0);
        chk("t6_gnt_wait2", 64'(gnt), 64'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_fetch_arbiter.md
Name: sample_fetch_arbiter

Overview:
- Shares the multi-thread random-word buffer (NUM_THREADS ready/rd/data lanes) among NUM_REQ sampling consumers in the clk_sample domain.
- Picks one requester by round-robin, then picks a ready buffer thread by an independent round-robin.
- Captures that thread's 32-bit word, pulses the thread's rd for one cycle, and holds the word for the requester until it is acknowledged.

Parameters:
- NUM_REQ, 4, number of consumer requesters (≥2).
- NUM_THREADS, 4, number of buffer threads (matches buffer parallelism).
- TIMEOUT, 255, FETCH wait limit in cycles; used only with the optional feature.

Ports:
- clk_sample  in  1  sampling clock; all logic on posedge.
- rstn  in  1  reset; asynchronous assertion, active-low.
- req  in  NUM_REQ  level request per consumer.
- ack  in  NUM_REQ  consumer accepted the word; only the granted bit is honoured.
- buf_ready  in  NUM_THREADS  thread has a word available.
- buf_data  in  32*NUM_THREADS  thread words; lane t is bits [32t+31:32t].
- buf_rd  out  NUM_THREADS  one-cycle read pulse to the buffer thread.
- gnt  out  NUM_REQ  one-hot grant; held from FETCH through DELIVER.
- valid  out  1  data_out is valid for the granted requester.
- data_out  out  32  captured random word.
- thread_id  out  clog2(NUM_THREADS)  source thread of data_out.
- starve  out  1  one-cycle timeout pulse (optional feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_req = 0; rr_thr = 0. Reset asserted mid-operation aborts immediately: no buf_rd pulse is issued and any captured word is discarded.
- All outputs are registered.
- Requester pick: the first index with req high, scanning from rr_req upward and wrapping.
- Thread pick: the first index with buf_ready high and buf_rd low, scanning from rr_thr upward and wrapping.
- A thread whose buf_rd is high in the current cycle is masked, because its ready is stale for that cycle.
- IDLE: if any req is high, latch gnt = one-hot of the picked requester and go to FETCH. Otherwise stay in IDLE.
- FETCH: if any thread is eligible, at the clock edge:
  - data_out <= lane t; thread_id <= t;
  - buf_rd[t] <= 1 for exactly one cycle;
  - rr_thr <= (t+1) mod NUM_THREADS;
  - go to DELIVER with valid <= 1.
  - If no thread is eligible, stay in FETCH; gnt stays held.
- DELIVER: valid is held high with data_out and thread_id stable. When ack[granted] is high:
  - valid <= 0; gnt <= 0;
  - rr_req <= (granted+1) mod NUM_REQ;
  - go to IDLE.
- Acks from non-granted bits are ignored.
- Once granted, the requester's req is not re-sampled; the word is delivered even if req drops.
- Latency: req seen in IDLE at cycle 0 → gnt at cycle 1 → valid at cycle 2 when a thread is ready. Minimum occupancy is 3 cycles per word (IDLE, FETCH, DELIVER with same-cycle ack).
- ack arriving in the same cycle valid first rises is accepted.
- At most one buf_rd bit is high in any cycle; buf_rd is never high in two consecutive cycles for the same thread.
- Each buffer word is delivered to exactly one requester; no word is duplicated or dropped once buf_rd has pulsed.

Optional Feature:
- Macro: SAMPLE_FETCH_ARB_TIMEOUT_EN.
- Enabled:
  - An 8+ bit counter clears on FETCH entry and increments each FETCH cycle with no eligible thread.
  - When the count reaches TIMEOUT: pulse starve for 1 cycle, clear gnt, advance rr_req past the granted index, return to IDLE, and issue no buf_rd.
- Disabled: no counter; FETCH waits indefinitely; starve is tied to 0.

Test Plan:
1. Reset, then req=4'b0001 with buf_ready=4'b0001 and lane0=32'hA5A5_0001 → gnt=0001 at cycle 1; buf_rd=0001 for one cycle; valid=1, data_out=A5A5_0001, thread_id=0 at cycle 2; ack=0001 → gnt=0, valid=0 at the next cycle.
2. req=4'b1111 held, all threads ready, ack returned immediately → grant order 0,1,2,3,0; thread order 0,1,2,3,0; never two buf_rd bits high in one cycle.
3. buf_ready=0 during FETCH for 10 cycles, then buf_ready=4'b0100 with lane2=32'h0280F76B → gnt stays held through the wait; data_out=0280F76B, thread_id=2, buf_rd=0100 once.
4. In DELIVER, granted requester 1: ack=4'b0100 for 3 cycles, then ack=4'b0010 → valid stays high through the wrong acks and clears only after ack bit 1.
5. rstn pulsed low during FETCH with buf_ready=1111 → all outputs 0 immediately; no buf_rd pulse; after release, rr_req=0 and rr_thr=0 ordering restarts.
6. With SAMPLE_FETCH_ARB_TIMEOUT_EN and TIMEOUT=4: req=0001, buf_ready=0 → starve pulses once after 4 FETCH cycles, gnt clears, state returns to IDLE; without the macro, starve stays 0 and gnt stays held.
